systolic_loader_ctrl: RTL
=========================

// Module: systolic_loader_ctrl
// PURPOSE
//  Parametrised NxN systolic-array data loader. Arbitrates one shared read port between the
//  weight preload and feature streaming phases, and runs both as a single start/done FSM.
//  Preloads N*N weights through one-hot register enables, with optional reuse of loaded weights.
//  Streams F_COLS feature columns into the array with per-row skew and a zero-column drain.
//  Delays the result-select code by a fixed number of cycles. Sits between the SRAM and systolic_array.
// PARAMETERS
//  N        3   array dimension (rows = cols = N), 2..8
//  DW       8   data width of memory word / weight / feature
//  AW       6   memory address width; all address arithmetic is mod 2**AW
//  CW       4   width of feature-column count
//  SW       2   width of result-select code
//  RES_DLY  3   cycles of delay from res_sel_in to res_sel_out (>=1)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active low
//  start        in   1      1-cycle request; sampled only in IDLE
//  reuse_w      in   1      sampled with start: skip weight load if w_loaded=1
//  w_base       in   AW     weight base address, sampled with start
//  f_base       in   AW     feature base address, sampled with start
//  f_cols       in   CW     number of feature columns, sampled with start (0 allowed)
//  mem_addr     out  AW     shared read address
//  mem_rd       out  1      read strobe; mem_q is valid exactly 1 cycle later
//  mem_q        in   DW     read data
//  w_data       out  DW     weight bus to all B registers
//  w_en         out  N*N    one-hot weight enable; bit k = row k/N, col k%N
//  f_data       out  N*DW   skewed feature rows; row r at [r*DW +: DW]
//  f_en         out  1      array shift enable (one step per pulse)
//  busy         out  1      high from cycle after accepted start until done
//  w_loaded     out  1      weight registers hold a complete set
//  wl_done      out  1      1-cycle pulse: last weight written
//  done         out  1      1-cycle pulse: operation complete
//  res_sel_in   in   SW     result-select code from top-level control
//  res_sel_out  out  SW     res_sel_in delayed RES_DLY cycles
// BEHAVIOUR
//  Reset (async, rst=0): FSM=IDLE.
//  Reset outputs: mem_rd, mem_addr, w_en, w_data, f_data, f_en, busy, w_loaded, wl_done, done = 0.
//  Reset also zeroes every skew and delay stage, so res_sel_out = 0 for RES_DLY cycles after release.
//  Reset mid-operation aborts the operation; no done pulse is produced.
//  FSM states: IDLE -> WLOAD -> FLOAD -> DRAIN -> FIN -> IDLE.
//  IDLE: on start, latch inputs, busy=1 next cycle.
//   - reuse_w=1 and w_loaded=1 -> FLOAD, else WLOAD.
//   - start in any other state is ignored.
//  WLOAD: entering WLOAD clears w_loaded.
//   - N*N consecutive cycles with mem_rd=1, mem_addr = w_base+k, k=0..N*N-1.
//   - Cycle after read k: w_data=mem_q and w_en = (1<<k); all other cycles w_en = 0.
//   - In the cycle w_en[N*N-1] is asserted: wl_done=1, w_loaded=1 from the next cycle.
//   - The last read's data cycle overlaps the first FLOAD read; weight and feature data are
//     never returned in the same cycle because the data path routes by the registered phase of
//     the previous read.
//  FLOAD: f_cols*N reads, column-major, addr = f_base + c*N + r (c = column, r = row).
//   - Returned words fill an N-entry column shadow register.
//   - When row N-1 of a column lands, the column is pushed into the skew network and f_en=1
//     for that cycle, so there is one push every N cycles.
//   - Skew network: row r passes through r push-clocked stages, so column c reaches row r on
//     push c+r. Stages advance only on pushes.
//   - f_cols=0: FLOAD is skipped.
//  DRAIN: exactly N-1 consecutive cycles, each a push of an all-zero column with f_en=1.
//   - After DRAIN, every skew stage holds 0.
//   - Entered after the last real push, or directly when f_cols=0 (an empty drain still zeroes stages).
//  FIN: done=1 and busy=0 in the same cycle; return to IDLE.
//   - start in the cycle after FIN is accepted.
//  w_loaded survives operations; only reset or a new WLOAD clears it.
//  mem_addr holds its last value when mem_rd=0.
//  res_sel_out: free-running RES_DLY-stage shift register, independent of the FSM.
// TESTING
//  T1 reset: assert rst=0 mid-FLOAD -> all outputs 0 immediately; after release busy=0, w_loaded=0.
//  T2 weight load, N=3, w_base=6'h10, mem holds 1..9 -> mem_addr 0x10..0x18 on consecutive cycles;
//     w_en 001h..100h with w_data 1..9; wl_done on the 9th w_en.
//  T3 features, f_cols=2, f_base=0x20 holding 11..16 -> pushes:
//     (row0,row1,row2) = (11,0,0), (14,12,0), (0,15,13), (0,0,16); then done; 4 f_en pulses total.
//  T4 reuse: second start with reuse_w=1 -> no WLOAD reads, first mem_addr=f_base.
//     reuse_w=1 straight after reset -> full WLOAD runs.
//  T5 edge cases: f_cols=0 -> WLOAD, then N-1 zero pushes, then done.
//     start pulsed while busy -> ignored; address wrap w_base=0x3E -> addresses 0x3E,0x3F,0x00..
//  T6 res_sel: drive 0,1,2,3 on consecutive cycles -> identical sequence on res_sel_out 3 cycles later.

Source files
------------

// File: rtl/systolic_loader_ctrl_if.sv
// Shared SRAM read port used by the systolic loader.
// mem_q returns the addressed word one cycle after mem_rd.
interface systolic_loader_ctrl_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_q;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_q
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_q
  );
endinterface

// File: rtl/systolic_loader_ctrl.sv
// NxN systolic-array loader: weight preload, skewed feature
// streaming with zero drain, and a delayed result-select code.
module systolic_loader_ctrl #(
  parameter int N       = 3,
  parameter int DW      = 8,
  parameter int AW      = 6,
  parameter int CW      = 4,
  parameter int SW      = 2,
  parameter int RES_DLY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  reuse_w,
  input  logic [AW-1:0]         w_base,
  input  logic [AW-1:0]         f_base,
  input  logic [CW-1:0]         f_cols,
  systolic_loader_ctrl_if.master mem,
  output logic [DW-1:0]         w_data,
  output logic [N*N-1:0]        w_en,
  output logic [N*DW-1:0]       f_data,
  output logic                  f_en,
  output logic                  busy,
  output logic                  w_loaded,
  output logic                  wl_done,
  output logic                  done,
  input  logic [SW-1:0]         res_sel_in,
  output logic [SW-1:0]         res_sel_out
);

  localparam int NN = N * N;
  localparam int KW = $clog2(NN);
  localparam int TW = CW + KW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_FLOAD,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] r_q, r_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] fb_q, fb_d;
  logic [CW-1:0] fc_q, fc_d;
  logic          wl_q, wl_d;

  logic          rd_w_q, rd_w_d;
  logic          rd_f_q, rd_f_d;
  logic [KW-1:0] rd_idx_q, rd_idx_d;

  logic [DW-1:0] col_q [N-1];
  logic [DW-1:0] col_d [N-1];
  logic [DW-1:0] col_in [N];

  logic [SW-1:0] rs_q [RES_DLY];
  logic [SW-1:0] rs_d [RES_DLY];

  logic [TW-1:0] tot;
  logic [TW-1:0] cnt_inc;
  logic          push_f;

  assign tot     = TW'(fc_q) * TW'(N);
  assign cnt_inc = cnt_q + TW'(1);

  // Phase sequencing, address generation and weight-valid flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    addr_d  = addr_q;
    fb_d    = fb_q;
    fc_d    = fc_q;
    wl_d    = wl_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          fb_d  = f_base;
          fc_d  = f_cols;
          cnt_d = '0;
          r_d   = '0;
          if (reuse_w && wl_q) begin
            if (f_cols != '0) begin
              state_d = S_FLOAD;
              addr_d  = f_base;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            state_d = S_WLOAD;
            addr_d  = w_base;
            wl_d    = 1'b0;
          end
        end
      end
      S_WLOAD: begin
        if (cnt_q == TW'(NN - 1)) begin
          cnt_d = '0;
          if (fc_q != '0) begin
            state_d = S_FLOAD;
            addr_d  = fb_q;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          cnt_d  = cnt_inc;
          addr_d = addr_q + AW'(1);
        end
      end
      S_FLOAD: begin
        if (cnt_q == tot) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          r_d   = (r_q == KW'(N - 1)) ? '0 : r_q + KW'(1);
          if (cnt_inc != tot) addr_d = addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == TW'(N - 2)) begin
          state_d = S_FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (wl_done) wl_d = 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      addr_q  <= '0;
      fb_q    <= '0;
      fc_q    <= '0;
      wl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      addr_q  <= addr_d;
      fb_q    <= fb_d;
      fc_q    <= fc_d;
      wl_q    <= wl_d;
    end
  end

  assign mem.mem_rd   = (state_q == S_WLOAD) ||
                        ((state_q == S_FLOAD) && (cnt_q != tot));
  assign mem.mem_addr = addr_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done         = (state_q == S_FIN);
  assign w_loaded     = wl_q;

  // Tag each read so its data is routed by the phase that issued it.
  always_comb begin
    rd_w_d   = (state_q == S_WLOAD);
    rd_f_d   = (state_q == S_FLOAD) && (cnt_q != tot);
    rd_idx_d = rd_w_d ? cnt_q[KW-1:0] : r_q;
  end

  // Read-tag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_w_q   <= 1'b0;
      rd_f_q   <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_w_q   <= rd_w_d;
      rd_f_q   <= rd_f_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  assign w_en    = rd_w_q ? (NN'(1) << rd_idx_q) : '0;
  assign w_data  = rd_w_q ? mem.mem_q : '0;
  assign wl_done = rd_w_q && (rd_idx_q == KW'(NN - 1));
  assign push_f  = rd_f_q && (rd_idx_q == KW'(N - 1));
  assign f_en    = push_f || (state_q == S_DRAIN);

  // Column shadow capture and the column presented on a push.
  always_comb begin
    for (int i = 0; i < N - 1; i++) begin
      col_d[i] = col_q[i];
      if (rd_f_q && (rd_idx_q == KW'(i))) col_d[i] = mem.mem_q;
    end
    for (int i = 0; i < N; i++) col_in[i] = '0;
    if (push_f) begin
      for (int i = 0; i < N - 1; i++) col_in[i] = col_q[i];
      col_in[N-1] = mem.mem_q;
    end
  end

  // Column shadow registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N - 1; i++) col_q[i] <= '0;
    end else begin
      for (int i = 0; i < N - 1; i++) col_q[i] <= col_d[i];
    end
  end

  assign f_data[0 +: DW] = col_in[0];

  for (genvar r = 1; r < N; r++) begin : g_skew
    logic [DW-1:0] st_q [r];
    logic [DW-1:0] st_d [r];

    // Row r delay line, advanced only on pushes.
    always_comb begin
      for (int j = 0; j < r; j++) st_d[j] = st_q[j];
      if (f_en) begin
        st_d[0] = col_in[r];
        for (int j = 1; j < r; j++) st_d[j] = st_q[j-1];
      end
    end

    // Row r skew stages.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j < r; j++) st_q[j] <= '0;
      end else begin
        for (int j = 0; j < r; j++) st_q[j] <= st_d[j];
      end
    end

    assign f_data[r*DW +: DW] = f_en ? st_q[r-1] : '0;
  end

  // Result-select delay line shift.
  always_comb begin
    rs_d[0] = res_sel_in;
    for (int j = 1; j < RES_DLY; j++) rs_d[j] = rs_q[j-1];
  end

  // Result-select delay stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < RES_DLY; j++) rs_q[j] <= '0;
    end else begin
      for (int j = 0; j < RES_DLY; j++) rs_q[j] <= rs_d[j];
    end
  end

  assign res_sel_out = rs_q[RES_DLY-1];

endmodule
